// File: rtl/rambam_decoder.sv
// RAMBAM decoder: reduces the (8+d)-bit redundant residue modulo P one coefficient per cycle.
// Optional macro RAMBAM_DECODER_ZEROIZE_EN clears the residue after hand-off and blanks out_data when not valid.
module rambam_decoder #(
  parameter int d = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:7+d] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:7]   out_data
);

  localparam int W  = 8 + d;
  localparam int CW = $clog2(8 + d) + 1;
  localparam int IW = $clog2(W);
  localparam logic [8:0] P = 9'h11B;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_next;
  logic [W-1:0]    work, work_step, in_norm;
  logic [CW-1:0]   cnt;

  // Internally bit i of work is the x^i coefficient in a conventional descending vector.
  always_comb begin
    in_norm = '0;
    for (int i = 0; i < W; i++) in_norm[i] = in_data[i];
  end

  generate
    if (d > 0) begin : g_reduce
      logic [IW-1:0] base;
      always_comb begin
        base      = cnt[IW-1:0] - IW'(8);
        work_step = work;
        if (work[cnt[IW-1:0]]) work_step[base +: 9] = work[base +: 9] ^ P;
      end
    end else begin : g_passthru
      assign work_step = work;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = (d > 0) ? BUSY : DONE;
      BUSY: if (cnt == CW'(8)) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work <= '0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          work <= in_norm;
          cnt  <= CW'(W - 1);
        end
        BUSY: begin
          work <= work_step;
          cnt  <= cnt - CW'(1);
        end
`ifdef RAMBAM_DECODER_ZEROIZE_EN
        DONE: if (out_ready) work <= '0;
`endif
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    out_data = '0;
    for (int i = 0; i < 8; i++) begin
`ifdef RAMBAM_DECODER_ZEROIZE_EN
      out_data[i] = out_valid & work[i];
`else
      out_data[i] = work[i];
`endif
    end
  end

endmodule

// File: tb/tb_rambam_decoder.sv
// Directed self-checking bench for rambam_decoder with d=2; values are hex integers sum(bit[i]*2^i).
module tb_rambam_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [0:9] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [0:7] out_data;

  int vectors = 0;
  int miscompares = 0;

  rambam_decoder #(.d(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  // Port vectors are ascending, so bit i of the integer maps to index i explicitly.
  function automatic logic [0:9] to_port(input logic [9:0] v);
    logic [0:9] r;
    for (int i = 0; i < 10; i++) r[i] = v[i];
    return r;
  endfunction

  function automatic logic [7:0] from_port(input logic [0:7] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[i];
    return r;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full transaction with out_ready high; all checks happen on falling edges.
  task automatic apply_stimulus(input string tag, input logic [9:0] value, input logic [7:0] expv);
    @(negedge clk);
    check_output({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_data   = to_port(value);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check_output({tag, ".busy1_out_valid"}, 32'(out_valid), 32'd0);
    check_output({tag, ".busy1_in_ready"}, 32'(in_ready), 32'd0);
    @(negedge clk);
    check_output({tag, ".busy2_out_valid"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check_output({tag, ".done_out_valid"}, 32'(out_valid), 32'd1);
    check_output({tag, ".done_in_ready"}, 32'(in_ready), 32'd0);
    check_output({tag, ".out_data"}, 32'(from_port(out_data)), 32'(expv));
    @(negedge clk);
    check_output({tag, ".after_in_ready"}, 32'(in_ready), 32'd1);
    check_output({tag, ".after_out_valid"}, 32'(out_valid), 32'd0);
`ifdef RAMBAM_DECODER_ZEROIZE_EN
    check_output({tag, ".idle_out_data_zero"}, 32'(from_port(out_data)), 32'd0);
    check_output({tag, ".work_zeroized"}, 32'(dut.work), 32'd0);
`else
    check_output({tag, ".idle_out_data_held"}, 32'(from_port(out_data)), 32'(expv));
`endif
  endtask

  initial begin
    logic [7:0] a;
    logic [1:0] r;
    logic [9:0] rp;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_output("reset.in_ready", 32'(in_ready), 32'd1);
    check_output("reset.out_valid", 32'(out_valid), 32'd0);
    check_output("reset.out_data", 32'(from_port(out_data)), 32'd0);

    apply_stimulus("x8", 10'h100, 8'h1B);
    apply_stimulus("x9", 10'h200, 8'h36);
    apply_stimulus("x9x8", 10'h300, 8'h2D);
    apply_stimulus("noreduce", 10'h0A5, 8'hA5);
    apply_stimulus("masked57", 10'h261, 8'h57);
    apply_stimulus("allones", 10'h3FF, 8'hD2);

    // Backpressure: hold DONE for 5 cycles while in_valid pulses are ignored.
    @(negedge clk);
    in_valid = 1'b1; in_data = to_port(10'h200); out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("bp.out_valid", 32'(out_valid), 32'd1);
      check_output("bp.out_data", 32'(from_port(out_data)), 32'h36);
      check_output("bp.in_ready", 32'(in_ready), 32'd0);
      in_valid = i[0];
      in_data  = to_port(10'h100);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_output("bp.release_out_valid", 32'(out_valid), 32'd0);
    check_output("bp.release_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check_output("bp.single_transfer", 32'(out_valid), 32'd0);
    apply_stimulus("bp.followup", 10'h0A5, 8'hA5);

    // Reset during the first BUSY cycle discards the in-flight value.
    @(negedge clk);
    in_valid = 1'b1; in_data = to_port(10'h300);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("midrst.in_ready", 32'(in_ready), 32'd1);
    check_output("midrst.out_valid", 32'(out_valid), 32'd0);
    check_output("midrst.out_data", 32'(from_port(out_data)), 32'd0);
    @(negedge clk);
    check_output("midrst.stays_idle", 32'(out_valid), 32'd0);
    apply_stimulus("midrst.x8", 10'h100, 8'h1B);

    // Masked operands a ^ r*P, r of degree below 2, must all decode to a.
    for (int n = 0; n < 200; n++) begin
      a  = 8'($urandom_range(0, 255));
      r  = 2'($urandom_range(0, 3));
      rp = 10'h000;
      if (r[0]) rp = rp ^ 10'h11B;
      if (r[1]) rp = rp ^ 10'h236;
      apply_stimulus("rand", {2'b00, a} ^ rp, a);
    end

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
